mio_bus: RTL and testbench
==========================

MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 Parameter RAM_AW, 10, RAM word-address width; RAM region is 4*2^RAM_AW bytes from 0x00000000.
REQ-002 Parameter RAM_WAIT, 1, RAM synchronous read latency in cycles; legal range 1..7.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 CPU_MIO  in  1  CPU request; CPU holds it and all request fields stable until MIO_ready is sampled high.
REQ-006 mem_w  in  1  request type: 1 = write, 0 = read.
REQ-007 cpu_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_rdata  out  32  read data; valid when MIO_ready=1.
REQ-010 MIO_ready  out  1  one-cycle completion pulse.
REQ-011 ram_addr  out  RAM_AW  RAM word address, cpu_addr[RAM_AW+1:2].
REQ-012 ram_wdata  out  32  RAM write data.
REQ-013 ram_we  out  1  RAM write strobe.
REQ-014 ram_rdata  in  32  RAM read data, RAM_WAIT cycles after address.
REQ-015 sw  in  16  switch inputs.
REQ-016 led  out  16  LED register.
REQ-017 bus_err  out  1  sticky unmapped-access flag.

Function
REQ-018 Address decode: RAM if cpu_addr[31:RAM_AW+2]==0; GPIO at 0xF0000000; COUNTER at 0xF0000004; all else unmapped.
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE with CPU_MIO=1 at cycle T latches cpu_addr, cpu_wdata, mem_w and decoded region.
REQ-020 IDLE->ACCESS for RAM; IDLE->RESP for GPIO, COUNTER, unmapped; RESP->IDLE unconditionally.
REQ-021 ACCESS lasts exactly RAM_WAIT+1 cycles (T+1..T+1+RAM_WAIT), tracked by a 3-bit wait counter.
REQ-022 ram_addr/ram_wdata driven from latched registers, stable from T+1 through RESP.
REQ-023 ram_we high for exactly the first ACCESS cycle (T+1) of a RAM write, low otherwise.
REQ-024 RAM read: cpu_rdata captures ram_rdata at end of last ACCESS cycle; MIO_ready high at T+2+RAM_WAIT.
REQ-025 RAM write: MIO_ready high at T+2+RAM_WAIT (same latency as read).
REQ-026 Peripheral/unmapped: MIO_ready high at T+1; cpu_rdata captured at end of cycle T.
REQ-027 GPIO read returns {16'h0, sw}; GPIO write loads led <= cpu_wdata[15:0].
REQ-028 COUNTER: 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF->0; write loads cpu_wdata (write wins over increment that cycle); read returns value at cycle T.
REQ-029 Unmapped: write has no effect, read returns 0x00000000, bus_err set to 1 at end of T and held until reset.
REQ-030 MIO_ready high exactly one cycle per request; cpu_rdata holds value until next capture; write responses leave cpu_rdata unchanged.
REQ-031 CPU_MIO deasserted mid-transaction is ignored; transaction completes.
REQ-032 CPU_MIO still high in the cycle after RESP is a new request (back-to-back allowed, one idle cycle between responses).

Reset
REQ-033 rst=0 forces immediately: state IDLE, MIO_ready 0, ram_we 0, cpu_rdata 0, led 0, counter 0, bus_err 0, latched registers 0.
REQ-034 Reset mid-transaction aborts it with no response; RAM write already strobed at T+1 is not undone.

Structure
REQ-035 Shared package holds FSM state encoding, region enum, GPIO_ADDR=0xF0000000, CNT_ADDR=0xF0000004.
REQ-036 One sub-module mio_decode: combinational address-to-region decoder with RAM_AW parameter.

Verification
REQ-037 RAM_WAIT=1, write 0xDEADBEEF to 0x00000010 at T -> ram_we=1 only at T+1 with ram_addr=4, MIO_ready at T+3; then read 0x00000010 -> cpu_rdata=0xDEADBEEF with MIO_ready.
REQ-038 sw=0x5A5A, read 0xF0000000 at T -> MIO_ready at T+1, cpu_rdata=0x00005A5A; write 0x1234ABCD -> led=0xABCD.
REQ-039 Write 0xFFFFFFFE to 0xF0000004, read three cycles after write response -> value shows wrap past 0xFFFFFFFF to small value consistent with cycle count.
REQ-040 Read 0x80000000 -> cpu_rdata=0, MIO_ready at T+1, bus_err=1 and stays 1 after further valid accesses.
REQ-041 CPU_MIO held high continuously with RAM reads -> one MIO_ready per request, gap of one cycle, no duplicated ram_we.
REQ-042 rst low during ACCESS of a RAM read -> no MIO_ready, all outputs at reset values, next request after release completes normally.

Source files
------------

// File: rtl/mio_bus_pkg.sv
// Shared types and address map for the MIO bus bridge.
package mio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_GPIO = 2'd1,
        RG_CNT  = 2'd2,
        RG_NONE = 2'd3
    } region_t;

    localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

endpackage

// File: rtl/mio_decode.sv
// Combinational byte-address to region decoder; address bits [1:0] never matter.
module mio_decode
    import mio_bus_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic [31:2] addr,
    output region_t     region
);

    always_comb begin
        region = RG_NONE;
        if (addr[31:RAM_AW+2] == '0) begin
            region = RG_RAM;
        end else if (addr == GPIO_ADDR[31:2]) begin
            region = RG_GPIO;
        end else if (addr == CNT_ADDR[31:2]) begin
            region = RG_CNT;
        end
    end

endmodule

// File: rtl/mio_bus.sv
// CPU memory/IO bridge: synchronous RAM with fixed wait states, GPIO, free-running counter.
//   state     | meaning
//   ST_IDLE   | waiting for CPU_MIO; peripheral accesses complete here
//   ST_ACCESS | RAM address/data presented for RAM_WAIT+1 cycles
//   ST_RESP   | MIO_ready pulse, then back to idle
module mio_bus
    import mio_bus_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              bus_err
);

    localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT);

    state_t            state, state_nx;
    region_t           dec_region, lat_region;
    logic [RAM_AW-1:0] lat_word;
    logic [31:0]       lat_wdata;
    logic              lat_w;
    logic [2:0]        wait_cnt;
    logic [31:0]       counter;
    logic              accept;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    mio_decode #(.RAM_AW(RAM_AW)) u_decode (
        .addr   (cpu_addr[31:2]),
        .region (dec_region)
    );

    assign accept    = (state == ST_IDLE) && CPU_MIO;
    assign ram_addr  = lat_word;
    assign ram_wdata = lat_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        MIO_ready = 1'b0;
        ram_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    state_nx = (dec_region == RG_RAM) ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                // the write strobe belongs to the first wait-state cycle only
                ram_we = lat_w && (lat_region == RG_RAM) && (wait_cnt == WAIT_INIT);
                if (wait_cnt == 3'd0) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                MIO_ready = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_word   <= '0;
            lat_wdata  <= '0;
            lat_w      <= 1'b0;
            lat_region <= RG_RAM;
            wait_cnt   <= 3'd0;
            cpu_rdata  <= '0;
            led        <= '0;
            counter    <= '0;
            bus_err    <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (accept) begin
                lat_word   <= cpu_addr[RAM_AW+1:2];
                lat_wdata  <= cpu_wdata;
                lat_w      <= mem_w;
                lat_region <= dec_region;
                wait_cnt   <= WAIT_INIT;
                case (dec_region)
                    RG_GPIO: begin
                        if (mem_w) led <= cpu_wdata[15:0];
                        else       cpu_rdata <= {16'h0000, sw};
                    end
                    RG_CNT: begin
                        // a load overrides the increment scheduled above
                        if (mem_w) counter <= cpu_wdata;
                        else       cpu_rdata <= counter;
                    end
                    RG_NONE: begin
                        bus_err <= 1'b1;
                        if (!mem_w) cpu_rdata <= '0;
                    end
                    default: ;
                endcase
            end else if (state == ST_ACCESS) begin
                if (wait_cnt != 3'd0) begin
                    wait_cnt <= wait_cnt - 3'd1;
                end else if (!lat_w && (lat_region == RG_RAM)) begin
                    cpu_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mio_bus.sv
// Bench for mio_bus: directed vector table, multi-cycle corner sequences, randomized traffic vs a reference model.
module tb_mio_bus;

    localparam int RAM_AW   = 10;
    localparam int RAM_WAIT = 1;
    localparam int RAM_LAT  = 2 + RAM_WAIT;
    localparam int B2B_PER  = 3 + RAM_WAIT;
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              CPU_MIO = 1'b0;
    logic              mem_w = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [15:0]       sw = '0;
    logic [15:0]       led;
    logic              bus_err;

    mio_bus #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .MIO_ready (MIO_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw        (sw),
        .led       (led),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // external synchronous RAM with RAM_WAIT cycles of read latency
    logic [31:0] ram     [0:RAM_WORDS-1] = '{default: 32'h0};
    logic [31:0] rd_pipe [0:RAM_WAIT-1]  = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        rd_pipe[0] <= ram[ram_addr];
        for (int k = 1; k < RAM_WAIT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rdata = rd_pipe[RAM_WAIT-1];

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // reference model state
    logic [31:0] ref_mem [0:RAM_WORDS-1] = '{default: 32'h0};
    logic [15:0] led_m;
    logic        err_m;
    logic [31:0] rd_m;
    logic [31:0] cnt_base;
    int          cnt_cyc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (a < (32'd4 << RAM_AW)) return 0;
        if (wa == 32'hF000_0000)   return 1;
        if (wa == 32'hF000_0004)   return 2;
        return 3;
    endfunction

    // one request from an idle cycle; returns in the idle cycle after the response
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit drop, input int exp_lat, input string nm,
                          output logic [31:0] rd);
        int n, we_n, we_at;
        bit is_ram, addr_ok, wdata_ok;
        is_ram = (region_of(a) == 0);
        CPU_MIO = 1'b1; mem_w = w; cpu_addr = a; cpu_wdata = d;
        n = 0; we_n = 0; we_at = -1; addr_ok = 1'b1; wdata_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (drop && n == 1) CPU_MIO = 1'b0;
            if (ram_we) begin we_n++; we_at = n; end
            if (is_ram && ram_addr !== a[RAM_AW+1:2]) addr_ok = 1'b0;
            if (is_ram && ram_wdata !== d) wdata_ok = 1'b0;
        end while (!MIO_ready && n < 40);
        CPU_MIO = 1'b0;
        rd = cpu_rdata;
        chk({nm, "/latency"}, n, exp_lat);
        chk({nm, "/we_count"}, we_n, (w && is_ram) ? 1 : 0);
        if (w && is_ram) chk({nm, "/we_cycle"}, we_at, 1);
        if (is_ram) begin
            chk({nm, "/ram_addr_stable"}, addr_ok, 1);
            chk({nm, "/ram_wdata_stable"}, wdata_ok, 1);
        end
        @(posedge clk); #1;
        chk({nm, "/ready_one_cycle"}, MIO_ready, 0);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit drop, input string nm, output logic [31:0] got);
        int rg, c0, idx;
        logic [31:0] exp_rd;
        rg = region_of(a);
        c0 = cyc;
        idx = int'(a[RAM_AW+1:2]);
        exp_rd = rd_m;
        case (rg)
            0: if (w) ref_mem[idx] = d; else exp_rd = ref_mem[idx];
            1: if (w) led_m = d[15:0]; else exp_rd = {16'h0, sw};
            2: begin
                if (!w) exp_rd = cnt_base + 32'(c0 - cnt_cyc);
                if (w) begin cnt_base = d; cnt_cyc = c0 + 1; end
            end
            default: begin err_m = 1'b1; if (!w) exp_rd = 32'h0; end
        endcase
        rd_m = exp_rd;
        do_req(w, a, d, drop, (rg == 0) ? RAM_LAT : 1, nm, got);
        chk({nm, "/rdata"}, got, exp_rd);
        chk({nm, "/led"}, led, led_m);
        chk({nm, "/bus_err"}, bus_err, err_m);
    endtask

    // CPU_MIO held high for k back-to-back RAM requests to the same address
    task automatic held(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int k, input string nm);
        int idx, len;
        bit rdy_exp, we_exp;
        idx = int'(a[RAM_AW+1:2]);
        if (w) ref_mem[idx] = d; else rd_m = ref_mem[idx];
        len = k * B2B_PER - 1;
        CPU_MIO = 1'b1; mem_w = w; cpu_addr = a; cpu_wdata = d;
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            rdy_exp = ((n % B2B_PER) == RAM_LAT);
            we_exp  = w && ((n % B2B_PER) == 1);
            chk($sformatf("%s/ready@%0d", nm, n), MIO_ready, rdy_exp);
            chk($sformatf("%s/we@%0d", nm, n), ram_we, we_exp);
            if (rdy_exp) chk($sformatf("%s/rdata@%0d", nm, n), cpu_rdata, rd_m);
        end
        CPU_MIO = 1'b0;
        @(posedge clk); #1;
        chk({nm, "/ready_end"}, MIO_ready, 0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a, d;
        int sel;
        logic w;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h5A5A, 32'h0000_5A5A, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 32'hF000_0000, 32'h1234_ABCD, 16'h5A5A, 32'h0000_5A5A, 16'hABCD, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0FFF, 32'hCAFE_0001, 16'h5A5A, 32'h0000_5A5A, 16'hABCD, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0FFC, 32'h0,         16'h5A5A, 32'hCAFE_0001, 16'hABCD, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_1000, 32'h0,         16'h5A5A, 32'h0000_0000, 16'hABCD, 1'b1};
        tbl[7]  = '{1'b1, 32'hF000_0008, 32'h1111_1111, 16'h5A5A, 32'h0000_0000, 16'hABCD, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0013, 32'h0,         16'h5A5A, 32'hDEAD_BEEF, 16'hABCD, 1'b1};
        tbl[9]  = '{1'b0, 32'hF000_0002, 32'h0,         16'h0001, 32'h0000_0001, 16'hABCD, 1'b1};
        tbl[10] = '{1'b0, 32'h8000_0000, 32'h0,         16'h0001, 32'h0000_0000, 16'hABCD, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 16'h0001, 32'h0000_0000, 16'hABCD, 1'b1};
        tbl[12] = '{1'b0, 32'h0000_0000, 32'h0,         16'h0001, 32'h0BAD_F00D, 16'hABCD, 1'b1};

        led_m = '0; err_m = 1'b0; rd_m = '0; cnt_base = '0; cnt_cyc = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/ready", MIO_ready, 0);
        chk("reset/ram_we", ram_we, 0);
        chk("reset/rdata", cpu_rdata, 0);
        chk("reset/led", led, 0);
        chk("reset/bus_err", bus_err, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            sw = tbl[i].sw;
            txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, 1'b0, $sformatf("vec%0d", i), got);
            chk($sformatf("vec%0d/tbl_rdata", i), got, tbl[i].exp_rd);
            chk($sformatf("vec%0d/tbl_led", i), led, tbl[i].exp_led);
            chk($sformatf("vec%0d/tbl_err", i), bus_err, tbl[i].exp_err);
        end

        // counter load near the top, then read a few cycles later
        txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0, "cnt_wr", got);
        repeat (3) begin @(posedge clk); #1; end
        txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, "cnt_rd", got);
        chk("cnt_wrap", got, 32'h0000_0002);

        // CPU_MIO dropped right after acceptance
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b1, "drop_rd", got);
        txn(1'b1, 32'h0000_0020, 32'h7777_0000, 1'b1, "drop_wr", got);

        held(1'b0, 32'h0000_0010, 32'h0, 3, "b2b_rd");
        held(1'b1, 32'h0000_0024, 32'h5555_AAAA, 2, "b2b_wr");
        txn(1'b0, 32'h0000_0024, 32'h0, 1'b0, "b2b_wr_check", got);

        // reset in the middle of a RAM read
        CPU_MIO = 1'b1; mem_w = 1'b0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        CPU_MIO = 1'b0;
        #1;
        chk("midrst/ready", MIO_ready, 0);
        chk("midrst/ram_we", ram_we, 0);
        chk("midrst/rdata", cpu_rdata, 0);
        chk("midrst/led", led, 0);
        chk("midrst/bus_err", bus_err, 0);
        chk("midrst/ram_addr", ram_addr, 0);
        chk("midrst/ram_wdata", ram_wdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst/no_ready%0d", i), MIO_ready, 0);
        end
        rst = 1'b1;
        led_m = '0; err_m = 1'b0; rd_m = '0; cnt_base = '0; cnt_cyc = 0;
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, "postrst_rd", got);
        txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, "postrst_cnt", got);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (sel <= 3)      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            else if (sel == 4) a = (32'($urandom_range(0, RAM_WORDS-1)) << 2) | 32'($urandom_range(0, 3));
            else if (sel <= 6) a = 32'hF000_0000 | 32'($urandom_range(0, 3));
            else if (sel == 7) a = 32'hF000_0004 | 32'($urandom_range(0, 3));
            else               a = $urandom;
            sw = 16'($urandom);
            txn(w, a, d, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i), got);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
